// File: rtl/dc_coef_fetch.sv
// DC coefficient fetcher: reads word 0 of each 8x8 block of a slice component and streams it out.
// Optional DC_FETCH_DELTA_EN: emit differences between consecutive DC values instead of raw values.
module dc_coef_fetch #(
  parameter int COEF_W       = 16,
  parameter int MAX_BLOCKS   = 32,
  parameter int BLOCK_STRIDE = 64,
  parameter int ADDR_W       = 11,
  parameter int CNT_W        = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  block_num,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [COEF_W-1:0] mem_rdata,
  output logic              dc_valid,
  output logic [COEF_W:0]   dc_data,
  input  logic              dc_ready,
  output logic [CNT_W-1:0]  dc_index,
  output logic              dc_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, OUT, DONE} state_t;

  localparam logic [CNT_W-1:0]  MAX_N  = CNT_W'(MAX_BLOCKS);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BLOCK_STRIDE);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COEF_W:0]   data_q, data_d;
  logic [COEF_W:0]   coef_word;
  logic              accept, handshake, is_last;

  assign accept    = (state_q == IDLE) && start;
  assign handshake = (state_q == OUT) && dc_ready;
  assign is_last   = (idx_q == n_q - CNT_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (block_num == '0) ? DONE : READ;
      READ:    state_d = WAIT;
      WAIT:    state_d = OUT;
      OUT:     if (dc_ready) state_d = is_last ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mem_rd_en = (state_q == READ);
    dc_valid  = (state_q == OUT);
    dc_last   = (state_q == OUT) && is_last;
    done      = (state_q == DONE);
    mem_addr  = addr_q;
    dc_data   = data_q;
    dc_index  = idx_q;
  end

`ifdef DC_FETCH_DELTA_EN
  logic [COEF_W-1:0] prev_q, prev_d;

  // prev + delta recovers the accepted coefficient exactly modulo 2^COEF_W,
  // so no separate raw-coefficient register is needed.
  always_comb begin
    prev_d = prev_q;
    if (accept)         prev_d = '0;
    else if (handshake) prev_d = prev_q + data_q[COEF_W-1:0];
    coef_word = {mem_rdata[COEF_W-1], mem_rdata} - {prev_q[COEF_W-1], prev_q};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev_q <= '0;
    else          prev_q <= prev_d;
  end
`else
  assign coef_word = {mem_rdata[COEF_W-1], mem_rdata};
`endif

  // Address is an accumulator, loaded only when entering READ so it holds elsewhere.
  always_comb begin
    n_d    = n_q;
    idx_d  = idx_q;
    addr_d = addr_q;
    data_d = data_q;
    if (accept) begin
      n_d   = (block_num > MAX_N) ? MAX_N : block_num;
      idx_d = '0;
      if (block_num != '0) addr_d = base_addr;
    end
    if (state_q == WAIT) data_d = coef_word;
    if (handshake && !is_last) begin
      idx_d  = idx_q + CNT_W'(1);
      addr_d = addr_q + STRIDE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n_q    <= '0;
      idx_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      n_q    <= n_d;
      idx_q  <= idx_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_dc_coef_fetch.sv
// Self-checking bench for dc_coef_fetch: randomized passes checked against a behavioural model.
// Works for both builds; define DC_FETCH_DELTA_EN consistently for RTL and bench.
`timescale 1ns/1ps
module tb_dc_coef_fetch;
  localparam int COEF_W       = 16;
  localparam int MAX_BLOCKS   = 32;
  localparam int BLOCK_STRIDE = 64;
  localparam int ADDR_W       = 11;
  localparam int CNT_W        = 6;
  localparam int MEM_WORDS    = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              start = 1'b0;
  logic              dc_ready = 1'b1;
  logic [CNT_W-1:0]  block_num = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [COEF_W-1:0] mem_rdata;
  logic              dc_valid;
  logic [COEF_W:0]   dc_data;
  logic [CNT_W-1:0]  dc_index;
  logic              dc_last, busy, done;

  logic [COEF_W-1:0] mem [MEM_WORDS];

  typedef struct { int addr; int cyc; } rd_t;
  typedef struct { logic [COEF_W:0] d; int idx; logic last; int cyc; } out_t;
  typedef struct { int base; int bn; bit mid; int stall; bit fixed; } case_t;

  int   checks = 0, errors = 0, cyc = 0, stall_err = 0;
  rd_t  rd_q[$];
  out_t out_q[$];
  int   start_q[$];
  int   done_q[$];
  logic             stall_prev = 1'b0;
  logic [COEF_W:0]  sv_data;
  logic [CNT_W-1:0] sv_idx;
  logic             sv_last;

  always #5 clock = ~clock;

  dc_coef_fetch #(
    .COEF_W(COEF_W), .MAX_BLOCKS(MAX_BLOCKS), .BLOCK_STRIDE(BLOCK_STRIDE),
    .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .block_num(block_num),
    .base_addr(base_addr), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .dc_valid(dc_valid), .dc_data(dc_data),
    .dc_ready(dc_ready), .dc_index(dc_index), .dc_last(dc_last),
    .busy(busy), .done(done)
  );

  // Synchronous memory: data valid only the cycle after a read, garbage otherwise.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    else           mem_rdata <= COEF_W'($urandom);
  end

  // Observer: logs reads, handshakes, starts and done pulses with their cycle numbers.
  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && (!dc_valid || mem_rd_en || dc_data !== sv_data ||
                         dc_index !== sv_idx || dc_last !== sv_last))
        stall_err++;
      stall_prev = dc_valid && !dc_ready;
      sv_data = dc_data;
      sv_idx  = dc_index;
      sv_last = dc_last;
      if (start && !busy)      start_q.push_back(cyc);
      if (mem_rd_en)           rd_q.push_back('{int'(mem_addr), cyc});
      if (dc_valid && dc_ready) out_q.push_back('{dc_data, int'(dc_index), dc_last, cyc});
      if (done)                done_q.push_back(cyc);
    end
  end

  function automatic int exp_addr(int base, int i);
    return (base + i * BLOCK_STRIDE) % MEM_WORDS;
  endfunction

  function automatic int coef_at(int a);
    return int'($signed(mem[a]));
  endfunction

  function automatic int exp_dc(int base, int i);
    int v = coef_at(exp_addr(base, i));
`ifdef DC_FETCH_DELTA_EN
    if (i > 0) v -= coef_at(exp_addr(base, i - 1));
`endif
    return v;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = COEF_W'($urandom);
  endtask

  task automatic clear_queues();
    rd_q.delete(); out_q.delete(); start_q.delete(); done_q.delete();
    stall_err = 0;
  endtask

  // Drives one pass; optionally stalls index stall_idx for 5 cycles and pokes start while busy.
  task automatic run_pass(input int base, input int bn, input bit mid_start,
                          input int stall_idx, output bit timed_out);
    int stalled = 0;
    @(posedge clock); #1;
    base_addr = ADDR_W'(base); block_num = CNT_W'(bn); start = 1'b1; dc_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; block_num = CNT_W'($urandom); base_addr = ADDR_W'($urandom);
    timed_out = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (done) begin timed_out = 1'b0; break; end
      dc_ready = 1'b1; start = 1'b0;
      if (dc_valid && int'(dc_index) == stall_idx && stalled < 5) begin
        dc_ready = 1'b0; stalled++;
      end
      if (mid_start && (c == 2 || c == 7)) start = 1'b1;
      @(posedge clock); #1;
    end
    start = 1'b0; dc_ready = 1'b1;
    repeat (2) @(posedge clock); #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0; start = 1'b0; dc_ready = 1'b1;
    repeat (3) @(posedge clock); #1;
    checks++;
    if ({mem_rd_en, dc_valid, dc_last, busy, done} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, expected 00000", {mem_rd_en, dc_valid, dc_last, busy, done});
    end
    checks++;
    if (mem_addr !== '0 || dc_data !== '0 || dc_index !== '0) begin
      errors++; $display("FAIL reset_data: got addr=%0d data=%0d idx=%0d, expected 0", mem_addr, dc_data, dc_index);
    end
    reset_n = 1'b1;
    clear_queues();
    repeat (6) @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, expected 0", busy); end
    checks++;
    if (rd_q.size() + out_q.size() + done_q.size() != 0) begin
      errors++; $display("FAIL idle_activity: got %0d events, expected 0", rd_q.size() + out_q.size() + done_q.size());
    end
  endtask

  task automatic test_passes();
    case_t tbl[$];
    int    sc_exp[4];
`ifdef DC_FETCH_DELTA_EN
    sc_exp = '{10, 10, -25, 12};
`else
    sc_exp = '{10, 20, -5, 7};
`endif
    tbl.push_back('{0, 4, 1'b0, -1, 1'b1});
    tbl.push_back('{int'($urandom_range(2047, 0)), 4, 1'b0, 1, 1'b0});
    tbl.push_back('{5, 0, 1'b0, -1, 1'b0});
    tbl.push_back('{2040, 40, 1'b0, -1, 1'b0});
    tbl.push_back('{int'($urandom_range(2047, 0)), 7, 1'b1, -1, 1'b0});
    for (int r = 0; r < 4; r++)
      tbl.push_back('{int'($urandom_range(2047, 0)), int'($urandom_range(20, 1)), 1'b0,
                      int'($urandom_range(6, 0)) - 1, 1'b0});
    foreach (tbl[t]) begin
      int n, s, e;
      bit to;
      fill_mem();
      if (tbl[t].fixed) begin
        mem[0] = 16'd10; mem[64] = 16'd20; mem[128] = 16'hFFFB; mem[192] = 16'd7;
      end
      clear_queues();
      run_pass(tbl[t].base, tbl[t].bn, tbl[t].mid, tbl[t].stall, to);
      n = (tbl[t].bn > MAX_BLOCKS) ? MAX_BLOCKS : tbl[t].bn;
      s = (start_q.size() > 0) ? start_q[0] : 0;
      checks++;
      if (to) begin errors++; $display("FAIL pass%0d timeout: got no done, expected done", t); end
      checks++;
      if (start_q.size() != 1) begin errors++; $display("FAIL pass%0d starts: got %0d, expected 1", t, start_q.size()); end
      checks++;
      if (rd_q.size() != n) begin errors++; $display("FAIL pass%0d reads: got %0d, expected %0d", t, rd_q.size(), n); end
      checks++;
      if (out_q.size() != n) begin errors++; $display("FAIL pass%0d words: got %0d, expected %0d", t, out_q.size(), n); end
      checks++;
      if (done_q.size() != 1) begin errors++; $display("FAIL pass%0d done_pulses: got %0d, expected 1", t, done_q.size()); end
      checks++;
      if (stall_err != 0) begin errors++; $display("FAIL pass%0d stall_stable: got %0d violations, expected 0", t, stall_err); end
      for (int i = 0; i < n && i < rd_q.size(); i++) begin
        checks++;
        if (rd_q[i].addr != exp_addr(tbl[t].base, i)) begin
          errors++; $display("FAIL pass%0d addr[%0d]: got %0d, expected %0d", t, i, rd_q[i].addr, exp_addr(tbl[t].base, i));
        end
      end
      if (n > 0 && rd_q.size() > 0) begin
        checks++;
        if (rd_q[0].cyc != s + 1) begin errors++; $display("FAIL pass%0d first_read_cyc: got %0d, expected %0d", t, rd_q[0].cyc, s + 1); end
      end
      for (int i = 0; i < n && i < out_q.size(); i++) begin
        checks++;
        if (out_q[i].d !== (COEF_W+1)'(exp_dc(tbl[t].base, i))) begin
          errors++; $display("FAIL pass%0d dc_data[%0d]: got %0d, expected %0d", t, i, $signed(out_q[i].d), exp_dc(tbl[t].base, i));
        end
        checks++;
        if (out_q[i].idx != i || out_q[i].last !== (i == n - 1)) begin
          errors++; $display("FAIL pass%0d index_last[%0d]: got %0d/%b, expected %0d/%b", t, i, out_q[i].idx, out_q[i].last, i, (i == n - 1));
        end
        e = ((i == 0) ? s + 3 : out_q[i-1].cyc + 3) + ((i == tbl[t].stall) ? 5 : 0);
        checks++;
        if (out_q[i].cyc != e) begin errors++; $display("FAIL pass%0d hs_cyc[%0d]: got %0d, expected %0d", t, i, out_q[i].cyc, e); end
        if (tbl[t].fixed && i < 4) begin
          checks++;
          if (out_q[i].d !== (COEF_W+1)'(sc_exp[i])) begin
            errors++; $display("FAIL pass%0d scenario_word[%0d]: got %0d, expected %0d", t, i, $signed(out_q[i].d), sc_exp[i]);
          end
        end
      end
      if (done_q.size() > 0) begin
        e = (n == 0) ? s + 1 : ((out_q.size() > 0) ? out_q[out_q.size()-1].cyc + 1 : -1);
        checks++;
        if (done_q[0] != e) begin errors++; $display("FAIL pass%0d done_cyc: got %0d, expected %0d", t, done_q[0], e); end
      end
      $display("pass %0d: base=%0d block_num=%0d words=%0d", t, tbl[t].base, tbl[t].bn, out_q.size());
    end
  endtask

  task automatic test_reset_midpass();
    int base = int'($urandom_range(2047, 0));
    int base2 = int'($urandom_range(2047, 0));
    int seen = 0;
    bit found = 1'b0, to;
    fill_mem();
    clear_queues();
    @(posedge clock); #1;
    base_addr = ADDR_W'(base); block_num = CNT_W'(5); start = 1'b1; dc_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (mem_rd_en) seen++;
      if (seen == 3) begin found = 1'b1; break; end
      @(posedge clock); #1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midreset_reach: got %0d reads, expected 3", seen); end
    @(posedge clock); #1;
    checks++;
    if ({busy, mem_rd_en, dc_valid} !== 3'b100) begin
      errors++; $display("FAIL midreset_wait_state: got %b, expected 100", {busy, mem_rd_en, dc_valid});
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd_en, dc_valid, dc_last, busy, done} !== 5'b0) begin
      errors++; $display("FAIL midreset_ctrl: got %b, expected 00000", {mem_rd_en, dc_valid, dc_last, busy, done});
    end
    checks++;
    if (mem_addr !== '0 || dc_data !== '0 || dc_index !== '0) begin
      errors++; $display("FAIL midreset_data: got addr=%0d data=%0d idx=%0d, expected 0", mem_addr, dc_data, dc_index);
    end
    repeat (2) @(posedge clock); #1;
    reset_n = 1'b1;
    clear_queues();
    run_pass(base2, 2, 1'b0, -1, to);
    checks++;
    if (to || done_q.size() != 1) begin errors++; $display("FAIL after_reset_done: got %0d pulses, expected 1", done_q.size()); end
    checks++;
    if (out_q.size() != 2) begin errors++; $display("FAIL after_reset_words: got %0d, expected 2", out_q.size()); end
    for (int i = 0; i < 2 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].d !== (COEF_W+1)'(exp_dc(base2, i))) begin
        errors++; $display("FAIL after_reset_data[%0d]: got %0d, expected %0d", i, $signed(out_q[i].d), exp_dc(base2, i));
      end
    end
    $display("midpass reset: recovered pass words=%0d", out_q.size());
  endtask

  initial begin
    test_reset();
    test_passes();
    test_reset_midpass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dc_coef_fetch.md
DC_COEF_FETCH -- requirements
Module: dc_coef_fetch

Interface
REQ-001 The block SHALL have parameter COEF_W, default 16, giving the coefficient word width in bits.
REQ-002 The block SHALL have parameter MAX_BLOCKS, default 32, giving the maximum 8x8 blocks per slice component.
REQ-003 The block SHALL have parameter BLOCK_STRIDE, default 64, giving the coefficient-memory words per block.
REQ-004 The block SHALL have parameter ADDR_W, default 11, giving the coefficient-memory address width.
REQ-005 The block SHALL have parameter CNT_W, default 6, giving the width of block_num and dc_index; it SHALL be able to hold MAX_BLOCKS.
REQ-006 The block SHALL have these ports: clock, input, 1 bit, rising-edge clock.
REQ-007 The block SHALL have these ports: reset_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have these ports: start, input, 1 bit, begin one component pass.
REQ-009 The block SHALL have these ports: block_num, input, CNT_W bits, blocks in this pass.
REQ-010 The block SHALL have these ports: base_addr, input, ADDR_W bits, address of block 0 coefficient 0.
REQ-011 The block SHALL have these ports: mem_rd_en and mem_addr, outputs, 1 and ADDR_W bits, synchronous read request.
REQ-012 The block SHALL have these ports: mem_rdata, input, COEF_W bits, read data valid exactly one cycle after mem_rd_en.
REQ-013 The block SHALL have these ports: dc_valid and dc_data, outputs, 1 and COEF_W+1 bits, DC output word, sign-extended.
REQ-014 The block SHALL have these ports: dc_ready, input, 1 bit, downstream accept.
REQ-015 The block SHALL have these ports: dc_index and dc_last, outputs, CNT_W and 1 bits, block number of the current word and final-word flag.
REQ-016 The block SHALL have these ports: busy and done, outputs, 1 bit each; done is a one-cycle pulse when a pass ends.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WAIT, OUT and DONE; busy SHALL be 1 in every state except IDLE.
REQ-018 In IDLE with start=1, the block SHALL latch n = min(block_num, MAX_BLOCKS) and base_addr, and clear idx to 0.
REQ-019 From IDLE with start=1, the FSM SHALL go to READ if n>0, or to DONE if n=0.
REQ-020 The block SHALL ignore start whenever busy=1.
REQ-021 In READ, the block SHALL drive mem_rd_en=1 and mem_addr=(base + idx*BLOCK_STRIDE) mod 2^ADDR_W, then go to WAIT.
REQ-022 In WAIT, the block SHALL register mem_rdata into the output holding register and go to OUT.
REQ-023 In OUT, the block SHALL drive dc_valid=1, dc_index=idx and dc_last=(idx==n-1).
REQ-024 While dc_valid=1 and dc_ready=0, dc_data, dc_index and dc_last SHALL be held stable.
REQ-025 In OUT with dc_ready=1: if dc_last=1 the FSM SHALL go to DONE; otherwise it SHALL increment idx and go to READ.
REQ-026 In DONE, the block SHALL assert done=1 for one cycle and then go to IDLE.
REQ-027 Timing: start accepted at edge E gives mem_rd_en high in cycle E+1 and the first dc_valid in cycle E+3.
REQ-028 With dc_ready held at 1, throughput SHALL be one DC word per 3 cycles.
REQ-029 mem_rd_en SHALL be 0 in every state other than READ, and mem_addr SHALL hold its last value outside READ.

Reset
REQ-030 Asserting reset_n=0 at any time, including mid-pass, SHALL immediately force the state to IDLE.
REQ-031 During reset, idx, dc_data, dc_index, mem_addr and the previous-DC register SHALL be cleared to 0.
REQ-032 During reset, dc_valid, dc_last, mem_rd_en, busy and done SHALL be 0.
REQ-033 After reset release, the block SHALL take no action until start is asserted.

Configuration
REQ-034 The macro DC_FETCH_DELTA_EN SHALL select the DC output format.
REQ-035 When DC_FETCH_DELTA_EN is defined: for idx=0, dc_data SHALL be the signed coefficient sign-extended to COEF_W+1 bits.
REQ-036 When DC_FETCH_DELTA_EN is defined: for idx>0, dc_data SHALL be coef[idx] - coef[idx-1], computed signed in COEF_W+1 bits with no overflow.
REQ-037 When DC_FETCH_DELTA_EN is defined: the previous-DC register SHALL update only on a dc_ready handshake, and SHALL reset to 0 at each accepted start.
REQ-038 When DC_FETCH_DELTA_EN is undefined: dc_data SHALL be the raw coefficient sign-extended to COEF_W+1 bits, and no previous-DC register SHALL exist.

Verification
REQ-039 Scenario: base=0, block_num=4, mem[0,64,128,192]=10,20,-5,7, dc_ready=1 -> mem_addr sequence 0,64,128,192; raw build outputs 10,20,-5,7; delta build outputs 10,10,-25,12; dc_last only on index 3; done 1 cycle after the last handshake.
REQ-040 Scenario: dc_ready=0 for 5 cycles during OUT on index 1 -> dc_valid stays 1, dc_data/dc_index stay stable, no further mem_rd_en, and the pass resumes on dc_ready=1.
REQ-041 Scenario: block_num=0 -> no mem_rd_en, no dc_valid, done pulses in cycle E+1.
REQ-042 Scenario: block_num=40 with MAX_BLOCKS=32 -> exactly 32 words, last dc_index=31; base=2040 -> block-1 address 56 (wrap).
REQ-043 Scenario: reset_n pulsed low in WAIT of index 2 -> all outputs 0 immediately; a following start with block_num=2 runs cleanly, and the delta build outputs raw coef[0] first.
REQ-044 Scenario: start pulsed while busy mid-pass -> ignored, and the current pass completes unchanged.
